// File: rtl/seven_seg_display_driver.sv
// seven_seg_display_driver
// Converts a 16-bit binary value to decimal with a sequential double-dabble and
// scans the low four decimal digits onto a common-anode seven-segment display.
// The digits selected by curDec blink while the user is editing. The decimal
// point of the leftmost digit lights when the value is above 9999.
module seven_seg_display_driver #(
  parameter logic [15:0] REFRESH_DIV = 16'd50000,
  parameter int          BLINK_BIT   = 23
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] displayValue,
  input  logic [3:0]  curDec,
  input  logic        editing,
  output logic [6:0]  segments,
  output logic [3:0]  anodes,
  output logic        dp,
  output logic        overflow
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_t;

  // Converter state
  conv_state_t        state_r;
  logic [15:0]        shift_r;
  logic [19:0]        scratch_r;
  logic [3:0]         bit_cnt_r;
  logic [15:0]        last_val_r;
  // Only the low four decimal digits are displayed; the ten-thousands digit
  // survives solely as the overflow flag.
  logic [15:0]        bcd_r;

  // Scan and blink state
  logic [15:0]        refresh_cnt_r;
  logic [1:0]         idx_r;
  logic [BLINK_BIT:0] blink_cnt_r;

  // Combinational helpers
  logic [35:0]        shifted_s;
  logic [3:0]         cur_nibble_s;
  logic [3:0]         digit_sel_s;
  logic               blank_s;
  logic [3:0]         anodes_s;
  logic               dp_s;

  // Adds 3 to every BCD nibble that is 5 or more (double-dabble correction).
  function automatic logic [19:0] add3_adjust(input logic [19:0] v);
    logic [19:0] r;
    r = v;
    for (int i = 0; i < 5; i++) begin
      if (r[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
      end else begin
        r[i*4 +: 4] = r[i*4 +: 4];
      end
    end
    return r;
  endfunction

  // Active-low segment pattern {g,f,e,d,c,b,a} for one decimal digit.
  function automatic logic [6:0] decode_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // One double-dabble step: correct the BCD nibbles, then shift BCD and binary together.
  always_comb begin
    shifted_s = {add3_adjust(scratch_r), shift_r} << 1;
  end

  // Converter FSM: samples a changed value, shifts it 16 times, then publishes the
  // whole result in one cycle so no partial conversion ever reaches the display.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r    <= ST_IDLE;
      shift_r    <= 16'd0;
      scratch_r  <= 20'd0;
      bit_cnt_r  <= 4'd0;
      last_val_r <= 16'd0;
      bcd_r      <= 16'd0;
      overflow   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (displayValue != last_val_r) begin
            shift_r    <= displayValue;
            last_val_r <= displayValue;
            scratch_r  <= 20'd0;
            bit_cnt_r  <= 4'd0;
            state_r    <= ST_SHIFT;
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          {scratch_r, shift_r} <= shifted_s;
          bit_cnt_r            <= bit_cnt_r + 4'd1;
          if (bit_cnt_r == 4'd15) begin
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_SHIFT;
          end
        end
        ST_DONE: begin
          bcd_r    <= scratch_r[15:0];
          overflow <= (scratch_r[19:16] != 4'd0);
          state_r  <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Refresh divider: holds each digit for REFRESH_DIV cycles, then advances the scan index.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      refresh_cnt_r <= 16'd0;
      idx_r         <= 2'd0;
    end else if (refresh_cnt_r == REFRESH_DIV - 16'd1) begin
      refresh_cnt_r <= 16'd0;
      idx_r         <= idx_r + 2'd1;
    end else begin
      refresh_cnt_r <= refresh_cnt_r + 16'd1;
      idx_r         <= idx_r;
    end
  end

  // Free-running blink counter; it wraps silently.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      blink_cnt_r <= '0;
    end else begin
      blink_cnt_r <= blink_cnt_r + {{BLINK_BIT{1'b0}}, 1'b1};
    end
  end

  // Select the BCD nibble of the digit currently being scanned.
  always_comb begin
    case (idx_r)
      2'd0:    cur_nibble_s = bcd_r[3:0];
      2'd1:    cur_nibble_s = bcd_r[7:4];
      2'd2:    cur_nibble_s = bcd_r[11:8];
      2'd3:    cur_nibble_s = bcd_r[15:12];
      default: cur_nibble_s = bcd_r[3:0];
    endcase
  end

  // Anode and decimal-point pattern for the scanned digit, including cursor blanking.
  always_comb begin
    digit_sel_s = 4'b0001 << idx_r;
    blank_s     = editing && curDec[idx_r] && blink_cnt_r[BLINK_BIT];
    if (blank_s) begin
      anodes_s = 4'b1111;
    end else begin
      anodes_s = ~digit_sel_s;
    end
    if ((idx_r == 2'd3) && overflow) begin
      dp_s = 1'b0;
    end else begin
      dp_s = 1'b1;
    end
  end

  // Display outputs are registered every cycle from the scan index.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      segments <= 7'h7F;
      anodes   <= 4'hF;
      dp       <= 1'b1;
    end else begin
      segments <= decode_digit(cur_nibble_s);
      anodes   <= anodes_s;
      dp       <= dp_s;
    end
  end

endmodule

// File: tb/tb_seven_seg_display_driver.sv
// Directed self-checking bench for seven_seg_display_driver with
// REFRESH_DIV=4 and BLINK_BIT=3. Inputs are driven and outputs sampled on the
// falling clock edge. cyc counts rising edges since the last reset edge.
module tb_seven_seg_display_driver;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] displayValue;
  logic [3:0]  curDec;
  logic        editing;
  logic [6:0]  segments;
  logic [3:0]  anodes;
  logic        dp;
  logic        overflow;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  seven_seg_display_driver #(
    .REFRESH_DIV(16'd4),
    .BLINK_BIT  (3)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .displayValue(displayValue),
    .curDec      (curDec),
    .editing     (editing),
    .segments    (segments),
    .anodes      (anodes),
    .dp          (dp),
    .overflow    (overflow)
  );

  always #5 CLK = ~CLK;

  // Edge counter since reset, used to predict scan position and blink phase.
  always @(posedge CLK) begin
    if (RESET) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Active-low segment patterns from the decode table.
  function automatic logic [6:0] seg_of(input int dg);
    case (dg)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int digit_of(input int v, input int d);
    int x;
    x = v;
    for (int i = 0; i < d; i++) x = x / 10;
    return x % 10;
  endfunction

  // Digit shown after rising edge e: each digit lasts 4 edges, first one is digit 0.
  function automatic int shown_digit(input int e);
    return ((e - 1) >> 2) & 3;
  endfunction

  function automatic logic [3:0] exp_anodes(input int e, input logic ed, input logic [3:0] cd);
    logic [3:0] a;
    int d;
    d = shown_digit(e);
    a = 4'b1111;
    a[d] = 1'b0;
    if (ed && cd[d] && ((((e - 1) >> 3) & 1) == 1)) a[d] = 1'b1;
    return a;
  endfunction

  task automatic step();
    @(negedge CLK);
  endtask

  // Leaves cyc at 15 mod 16 so the next rising edge is aligned to a scan start.
  task automatic align();
    for (int i = 0; i < 16; i++) begin
      if ((cyc % 16) != 15) step();
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; displayValue = 16'd0; curDec = 4'd0; editing = 1'b0;
    step();
    checks++; if (segments !== 7'h7F) begin failures++; $display("FAIL reset_segments got=%b exp=%b", segments, 7'h7F); end
    checks++; if (anodes !== 4'hF) begin failures++; $display("FAIL reset_anodes got=%b exp=%b", anodes, 4'hF); end
    checks++; if (dp !== 1'b1) begin failures++; $display("FAIL reset_dp got=%b exp=1", dp); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    RESET = 1'b0;
  endtask

  task automatic test_scan_zero();
    for (int i = 0; i < 32; i++) begin
      step();
      checks++; if (anodes !== exp_anodes(cyc, 1'b0, 4'd0)) begin failures++; $display("FAIL scan0_anodes cyc=%0d got=%b exp=%b", cyc, anodes, exp_anodes(cyc, 1'b0, 4'd0)); end
      checks++; if (segments !== 7'b1000000) begin failures++; $display("FAIL scan0_segments cyc=%0d got=%b exp=1000000", cyc, segments); end
      checks++; if (dp !== 1'b1) begin failures++; $display("FAIL scan0_dp cyc=%0d got=%b exp=1", cyc, dp); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL scan0_overflow cyc=%0d got=%b exp=0", cyc, overflow); end
    end
  endtask

  task automatic test_convert_1234();
    int k;
    align();
    displayValue = 16'd1234;
    k = cyc + 1;
    while (cyc < k + 17) step();
    checks++; if (segments !== seg_of(0)) begin failures++; $display("FAIL c1234_early cyc=%0d got=%b exp=%b", cyc, segments, seg_of(0)); end
    step();
    checks++; if (segments !== seg_of(4)) begin failures++; $display("FAIL c1234_latency cyc=%0d got=%b exp=%b", cyc, segments, seg_of(4)); end
    for (int i = 0; i < 16; i++) begin
      step();
      checks++; if (segments !== seg_of(digit_of(1234, shown_digit(cyc)))) begin failures++; $display("FAIL c1234_segments cyc=%0d got=%b exp=%b", cyc, segments, seg_of(digit_of(1234, shown_digit(cyc)))); end
      checks++; if (anodes !== exp_anodes(cyc, 1'b0, 4'd0)) begin failures++; $display("FAIL c1234_anodes cyc=%0d got=%b exp=%b", cyc, anodes, exp_anodes(cyc, 1'b0, 4'd0)); end
    end
  endtask

  task automatic test_overflow();
    int k;
    align();
    displayValue = 16'd65535;
    k = cyc + 1;
    while (cyc < k + 16) step();
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_early cyc=%0d got=%b exp=0", cyc, overflow); end
    step();
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set cyc=%0d got=%b exp=1", cyc, overflow); end
    for (int i = 0; i < 16; i++) begin
      step();
      checks++; if (segments !== seg_of(digit_of(65535, shown_digit(cyc)))) begin failures++; $display("FAIL ovf_segments cyc=%0d got=%b exp=%b", cyc, segments, seg_of(digit_of(65535, shown_digit(cyc)))); end
      checks++; if (dp !== ((shown_digit(cyc) == 3) ? 1'b0 : 1'b1)) begin failures++; $display("FAIL ovf_dp cyc=%0d got=%b", cyc, dp); end
    end
    align();
    displayValue = 16'd9999;
    k = cyc + 1;
    while (cyc < k + 16) step();
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_hold cyc=%0d got=%b exp=1", cyc, overflow); end
    step();
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear cyc=%0d got=%b exp=0", cyc, overflow); end
    for (int i = 0; i < 16; i++) begin
      step();
      checks++; if (segments !== seg_of(9)) begin failures++; $display("FAIL c9999_segments cyc=%0d got=%b exp=%b", cyc, segments, seg_of(9)); end
      checks++; if (dp !== 1'b1) begin failures++; $display("FAIL c9999_dp cyc=%0d got=%b exp=1", cyc, dp); end
    end
  endtask

  task automatic test_blink();
    logic [3:0] pats [5];
    logic       eds  [5];
    pats[0] = 4'b0100; eds[0] = 1'b1;
    pats[1] = 4'b0001; eds[1] = 1'b1;
    pats[2] = 4'b1111; eds[2] = 1'b1;
    pats[3] = 4'b0000; eds[3] = 1'b1;
    pats[4] = 4'b0100; eds[4] = 1'b0;
    for (int p = 0; p < 5; p++) begin
      curDec  = pats[p];
      editing = eds[p];
      for (int i = 0; i < 32; i++) begin
        step();
        checks++; if (anodes !== exp_anodes(cyc, editing, curDec)) begin failures++; $display("FAIL blink_anodes cur=%b ed=%b cyc=%0d got=%b exp=%b", curDec, editing, cyc, anodes, exp_anodes(cyc, editing, curDec)); end
      end
    end
    editing = 1'b0;
    curDec  = 4'd0;
  endtask

  task automatic test_mid_change();
    int k;
    int v;
    align();
    displayValue = 16'd100;
    k = cyc + 1;
    while (cyc < k + 4) step();
    displayValue = 16'd200;
    for (int i = 0; i < 40; i++) begin
      step();
      v = (cyc <= k + 17) ? 9999 : ((cyc <= k + 35) ? 100 : 200);
      checks++; if (segments !== seg_of(digit_of(v, shown_digit(cyc)))) begin failures++; $display("FAIL midchg_segments cyc=%0d got=%b exp=%b", cyc, segments, seg_of(digit_of(v, shown_digit(cyc)))); end
    end
  endtask

  task automatic test_reset_mid_shift();
    int v;
    displayValue = 16'd4321;
    for (int i = 0; i < 5; i++) step();
    RESET = 1'b1;
    displayValue = 16'd7;
    step();
    checks++; if (segments !== 7'h7F) begin failures++; $display("FAIL rst2_segments got=%b exp=%b", segments, 7'h7F); end
    checks++; if (anodes !== 4'hF) begin failures++; $display("FAIL rst2_anodes got=%b exp=%b", anodes, 4'hF); end
    checks++; if (dp !== 1'b1) begin failures++; $display("FAIL rst2_dp got=%b exp=1", dp); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst2_overflow got=%b exp=0", overflow); end
    RESET = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      v = (cyc <= 18) ? 0 : 7;
      checks++; if (segments !== seg_of(digit_of(v, shown_digit(cyc)))) begin failures++; $display("FAIL rst2_conv cyc=%0d got=%b exp=%b", cyc, segments, seg_of(digit_of(v, shown_digit(cyc)))); end
      checks++; if (anodes !== exp_anodes(cyc, 1'b0, 4'd0)) begin failures++; $display("FAIL rst2_scan cyc=%0d got=%b exp=%b", cyc, anodes, exp_anodes(cyc, 1'b0, 4'd0)); end
    end
  endtask

  initial begin
    RESET = 1'b1; displayValue = 16'd0; curDec = 4'd0; editing = 1'b0;
    test_reset();
    test_scan_zero();
    test_convert_1234();
    test_overflow();
    test_blink();
    test_mid_change();
    test_reset_mid_shift();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
